spi_frame_receiver: RTL
=======================

# spi_frame_receiver

- Receives configuration frames from the host MCU over a 3-wire SPI link (mode 0, LSB first).
- Sequences an internal serial-to-parallel word shifter and decodes a header word (start address plus word count).
- Issues one register-file write per data word with an auto-incrementing address.
- Sits between the MCU pins and the synth parameter register file, and reports frame completion or framing errors.

## Interface
- `WIDTH`, 32: bits per serial word; must be ≥ `ADDR_W`+8.
- `ADDR_W`, 8: register-file address width.
- `clk` in 1: system clock. One clock; all logic on posedge.
- `rstn` in 1: reset, synchronous, active-low.
- `sck` in 1: SPI clock from MCU, asynchronous to `clk`.
- `mosi` in 1: SPI data, asynchronous.
- `cs_n` in 1: SPI chip select, active-low, asynchronous.
- `wr_data` out `WIDTH`: assembled data word.
- `wr_addr` out `ADDR_W`: target address for `wr_data`.
- `wr_valid` out 1: one-cycle write strobe.
- `frame_done` out 1: one-cycle pulse, frame received correctly.
- `frame_error` out 1: one-cycle pulse, frame aborted or malformed.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Input synchronisers**
  - `sck`, `mosi` and `cs_n` each pass through 2-flop synchronisers.
  - Reset values: `sck` chain 0, `mosi` chain 0, `cs_n` chain 0.
  - Because the `cs_n` chain resets to 0, a frame already in progress across reset is ignored completely; reception needs a fresh high→low transition of `cs_n`.
- **Edge detection** uses one extra register per signal.
  - `sck_rise`: synced `sck` goes 0→1.
  - `cs_fall` / `cs_rise`: synced `cs_n` goes 1→0 / 0→1.
- **Shifter**
  - On each accepted `sck_rise`, synced `mosi` enters bit `WIDTH-1` and the word shifts right, so the first bit ends in bit 0.
  - Bit counter runs 0..`WIDTH-1` and wraps to 0; wrapping marks word complete.
- **FSM states**
  - IDLE: on `cs_fall` → HEADER; clear bit counter.
  - HEADER: on word complete, latch `addr` = word[`ADDR_W`-1:0] and `remaining` = word[`ADDR_W`+7:`ADDR_W`]. Go to DATA if `remaining`≠0, else DRAIN.
  - DATA: on word complete, pulse `wr_valid` with the word and `addr`. Then `addr`+1 (mod 2^`ADDR_W`) and `remaining`−1; if `remaining` becomes 0 → DRAIN.
  - DRAIN: any `sck_rise` sets `overrun`.
- **`cs_rise` handling**
  - From any non-IDLE state → IDLE.
  - Pulse `frame_done` if the state was DRAIN, `overrun`=0 and the bit counter is 0.
  - Otherwise pulse `frame_error`: mid-word, underrun in HEADER/DATA, or overrun.
  - Partial word is discarded; `overrun` and the bit counter are cleared.
- **Simultaneous events**
  - `cs_rise` and `sck_rise` in the same cycle: the `cs_rise` wins and the bit is dropped.
  - A `cs_rise` in IDLE has no effect.
- **Reset values**
  - All outputs and internal registers 0; state IDLE.
  - `wr_data` and `wr_addr` hold their last value between strobes.

## Timing
- `sck_rise` is detected 3 `clk` cycles after the pin edge: 2 sync stages plus the edge register.
- `wr_valid`, `wr_data` and `wr_addr` are registered.
  - The strobe occurs the cycle after the `sck_rise` detect of the word's last bit.
  - The strobe lasts exactly 1 cycle.
- `frame_done` / `frame_error` are asserted the cycle after `cs_rise` is detected; `busy` falls in that same cycle.
- SPI constraints: `sck` high and low each ≥ 3 `clk` periods; `cs_n` high ≥ 3 `clk` periods between frames.
- Back-to-back words need no gap; consecutive `wr_valid` pulses are ≥ 2·`WIDTH`·3 cycles apart.

## Test plan
- **Normal frame:** header 0x0000_0210 (addr 0x10, count 2), data 0xDEADBEEF, 0x12345678, then `cs_n` high.
  - → `wr_valid` ×2 at addr 0x10 then 0x11 with matching data.
  - → `frame_done` pulse; `frame_error` never asserted.
- **Address wrap:** header addr 0xFF, count 2.
  - → writes to 0xFF then 0x00.
  - → `frame_done`.
- **Aborts:**
  - `cs_n` rises after 17 bits of the second data word → exactly 1 `wr_valid`, then a `frame_error` pulse, then `busy`=0.
  - Header count 3 with only 2 words sent → `frame_error`.
  - Extra `sck` edges after the last word → `frame_error` and no extra write.
- **Zero count:** header count 0, then `cs_n` high.
  - → no `wr_valid`; `frame_done`.
- **Reset mid-frame:** `rstn` low for 2 cycles during a data word with `cs_n` held low, remaining bits clocked, then `cs_n` high.
  - → no `wr_valid`, no pulses.
  - → the next full frame is received correctly.

Source files
------------

// File: rtl/spi_frame_receiver.sv
// SPI (mode 0, LSB first) configuration frame receiver: header word gives start
// address and word count, each following word becomes one register-file write.
module spi_frame_receiver #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              sck_i,
  input  logic              mosi_i,
  input  logic              cs_n_i,
  output logic [WIDTH-1:0]  wr_data_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              wr_valid_o,
  output logic              frame_done_o,
  output logic              frame_error_o,
  output logic              busy_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, HEADER, DATA, DRAIN} state_e;

  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic cs_meta_q, cs_sync_q, cs_prev_q;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         remaining_q, remaining_d;
  logic               overrun_q, overrun_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic               wr_valid_q, wr_valid_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic             sck_rise, cs_fall, cs_rise, word_done;
  logic [WIDTH-1:0] word_in;

  // cs_n chain resets low so a frame already running across reset never looks like a fresh start
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      cs_meta_q   <= 1'b0;
      cs_sync_q   <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_meta_q  <= sck_i;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      mosi_meta_q <= mosi_i;
      mosi_sync_q <= mosi_meta_q;
      cs_meta_q   <= cs_n_i;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
    end
  end

  assign sck_rise  = sck_sync_q & ~sck_prev_q;
  assign cs_fall   = ~cs_sync_q & cs_prev_q;
  assign cs_rise   = cs_sync_q & ~cs_prev_q;
  assign word_in   = {mosi_sync_q, shift_q[WIDTH-1:1]};
  assign word_done = (bit_cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      overrun_q   <= 1'b0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      wr_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      overrun_q   <= overrun_d;
      wr_data_q   <= wr_data_d;
      wr_addr_q   <= wr_addr_d;
      wr_valid_q  <= wr_valid_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    overrun_d   = overrun_q;
    wr_data_d   = wr_data_q;
    wr_addr_d   = wr_addr_q;
    wr_valid_d  = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;

    if (state_q == IDLE) begin
      if (cs_fall) begin
        state_d   = HEADER;
        bit_cnt_d = '0;
        overrun_d = 1'b0;
      end
    end else if (cs_rise) begin
      // cs_rise takes priority over a coincident sck_rise; that bit is dropped
      state_d   = IDLE;
      bit_cnt_d = '0;
      overrun_d = 1'b0;
      if (state_q == DRAIN && !overrun_q && bit_cnt_q == '0) begin
        done_d = 1'b1;
      end else begin
        error_d = 1'b1;
      end
    end else if (sck_rise) begin
      shift_d   = word_in;
      bit_cnt_d = word_done ? '0 : bit_cnt_q + CNT_W'(1);
      case (state_q)
        HEADER: begin
          if (word_done) begin
            addr_d      = word_in[ADDR_W-1:0];
            remaining_d = word_in[ADDR_W+7:ADDR_W];
            state_d     = (word_in[ADDR_W+7:ADDR_W] != 8'd0) ? DATA : DRAIN;
          end
        end
        DATA: begin
          if (word_done) begin
            wr_valid_d  = 1'b1;
            wr_data_d   = word_in;
            wr_addr_d   = addr_q;
            addr_d      = addr_q + ADDR_W'(1);
            remaining_d = remaining_q - 8'd1;
            if (remaining_q == 8'd1) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          overrun_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign wr_data_o     = wr_data_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_valid_o    = wr_valid_q;
  assign frame_done_o  = done_q;
  assign frame_error_o = error_q;
  assign busy_o        = (state_q != IDLE);

endmodule
